// File: rtl/cache_pkg.sv
// L1 cache geometry constants, controller states and width helpers.
package cache_pkg;
  localparam int LINE_BITS = 256;
  localparam int OFFSET_W  = 5;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } cache_state_e;

  function automatic int calc_idx_w(int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(int sets);
    return 32 - OFFSET_W - calc_idx_w(sets);
  endfunction
endpackage

// File: rtl/rv32i_types.sv
// Core-wide scalar types shared by the RV32I datapath and its memory port.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;
endpackage

// File: rtl/cache_way.sv
// One cache way: valid/dirty/tag/line storage, tag compare and
// a byte-masked word write port alongside the whole-line fill port.
module cache_way
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic [2:0]           word_i,
  output logic                 hit_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [LINE_BITS-1:0] line_o,
  output logic [31:0]          rdata_o,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  input  logic                 fill_i,
  input  logic [LINE_BITS-1:0] fill_line_i,
  input  logic                 clr_dirty_i
);

  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] line_q [NUM_SETS];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = line_q[idx_i];
  assign hit_o   = valid_o && (tag_o == tag_i);
  assign rdata_o = line_o[{word_i, 5'b0} +: 32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; valid gates them.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i]  <= tag_i;
      line_q[idx_i] <= fill_line_i;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          line_q[idx_i][{word_i, 2'(b), 3'b0} +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/l1_cache.sv
// Set-associative write-back/write-allocate L1 cache with a
// CHECK/WRITEBACK/FILL controller and per-set round-robin victims.
module l1_cache
  import cache_pkg::*;
  import rv32i_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IDX_W = calc_idx_w(NUM_SETS);
  localparam int TAG_W = calc_tag_w(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic             req;
  logic             unused_addr;

  assign idx         = mem_address[OFFSET_W +: IDX_W];
  assign tag         = mem_address[31 -: TAG_W];
  assign word        = mem_address[4:2];
  assign req         = mem_read | mem_write;
  assign unused_addr = ^mem_address[1:0];

  logic [NUM_WAYS-1:0]  hit_w;
  logic [NUM_WAYS-1:0]  valid_w;
  logic [NUM_WAYS-1:0]  dirty_w;
  logic [NUM_WAYS-1:0]  we_w;
  logic [NUM_WAYS-1:0]  fill_w;
  logic [NUM_WAYS-1:0]  clr_w;
  logic [TAG_W-1:0]     tag_a   [NUM_WAYS];
  logic [LINE_BITS-1:0] line_a  [NUM_WAYS];
  rv32i_word            rdata_a [NUM_WAYS];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    cache_way #(
      .NUM_SETS (NUM_SETS),
      .IDX_W    (IDX_W),
      .TAG_W    (TAG_W)
    ) u_way (
      .clk_i       (clk),
      .rst_i       (rst),
      .idx_i       (idx),
      .tag_i       (tag),
      .word_i      (word),
      .hit_o       (hit_w[w]),
      .valid_o     (valid_w[w]),
      .dirty_o     (dirty_w[w]),
      .tag_o       (tag_a[w]),
      .line_o      (line_a[w]),
      .rdata_o     (rdata_a[w]),
      .we_i        (we_w[w]),
      .be_i        (mem_byte_enable),
      .wdata_i     (mem_wdata),
      .fill_i      (fill_w[w]),
      .fill_line_i (pmem_rdata),
      .clr_dirty_i (clr_w[w])
    );
  end

  cache_state_e     state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic             from_ptr_q, from_ptr_d;
  logic [WAY_W-1:0] ptr_q [NUM_SETS];

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vic_sel;
  logic             vic_by_ptr;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_w[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way beats the round-robin pointer.
  always_comb begin
    vic_sel    = ptr_q[idx];
    vic_by_ptr = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_w[w]) begin
        vic_sel    = WAY_W'(w);
        vic_by_ptr = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    from_ptr_d   = from_ptr_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    we_w         = '0;
    fill_w       = '0;
    clr_w        = '0;
    unique case (state_q)
      CHECK: begin
        if (req) begin
          if (hit_any) begin
            mem_resp = 1'b1;
            if (mem_write) begin
              we_w[hit_way] = 1'b1;
            end else begin
              mem_rdata = rdata_a[hit_way];
            end
          end else begin
            victim_d   = vic_sel;
            from_ptr_d = vic_by_ptr;
            state_d    = dirty_w[vic_sel] ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_a[victim_q], idx, 5'b0};
        pmem_wdata   = line_a[victim_q];
        if (pmem_resp) begin
          clr_w[victim_q] = 1'b1;
          state_d         = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, idx, 5'b0};
        if (pmem_resp) begin
          fill_w[victim_q] = 1'b1;
          state_d          = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CHECK;
      victim_q   <= '0;
      from_ptr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      from_ptr_q <= from_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else if (state_q == FILL && pmem_resp && from_ptr_q && NUM_WAYS > 1) begin
      ptr_q[idx] <= ptr_q[idx] + WAY_W'(1);
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Randomised bench for l1_cache against a flat-memory and
// set/way occupancy reference model.
module tb_l1_cache;

  localparam int SETS = 8;
  localparam int WAYS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  l1_cache #(.NUM_SETS(SETS), .NUM_WAYS(WAYS)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Flat view of memory as the CPU should see it, plus pmem backing store.
  logic [31:0]  refm [int unsigned];
  logic [255:0] pm   [int unsigned];

  function automatic logic [31:0] init_word(logic [31:0] a);
    if (a[31:2] == 30'h11) return 32'h1122_3344;
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (refm.exists(a >> 2)) return refm[a >> 2];
    return init_word({a[31:2], 2'b0});
  endfunction

  function automatic logic [255:0] ref_line(logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_rd({a[31:5], 3'(i), 2'b0});
    return l;
  endfunction

  function automatic logic [255:0] pm_line(logic [31:0] a);
    logic [255:0] l;
    if (pm.exists(a >> 5)) return pm[a >> 5];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word({a[31:5], 3'(i), 2'b0});
    return l;
  endfunction

  // Occupancy model: which line tag lives in which way, dirtiness, pointer.
  bit          mv [SETS][WAYS];
  bit          md [SETS][WAYS];
  logic [23:0] mt [SETS][WAYS];
  int          mp [SETS];

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0;
        md[s][w] = 0;
      end
    end
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int lat, output logic [31:0] rdata,
                        output int cyc, output int nwb,
                        output logic [31:0] wba, output logic [255:0] wbd,
                        output int nfl, output logic [31:0] fla);
    int          wait_n;
    logic [31:0] last_pa;
    bit          act_prev;
    bit          done;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a;
    mem_byte_enable = be; mem_wdata = wd;
    cyc = 0; nwb = 0; nfl = 0; wait_n = 0; done = 0; act_prev = 0;
    rdata = '0; wba = '0; wbd = '0; fla = '0; last_pa = '0;
    while (!done && cyc < 300) begin
      #1;
      chk("pmem_excl", pmem_read & pmem_write, 0);
      if (mem_resp) begin
        rdata = mem_rdata;
        done  = 1;
      end else begin
        if (pmem_read || pmem_write) begin
          if (act_prev) chk("pa_stable", pmem_address, last_pa);
          last_pa  = pmem_address;
          act_prev = 1;
          if (wait_n == lat) begin
            pmem_resp = 1'b1;
            if (pmem_write) begin
              nwb++;
              wba = pmem_address;
              wbd = pmem_wdata;
              pm[pmem_address >> 5] = pmem_wdata;
            end else begin
              nfl++;
              fla = pmem_address;
              pmem_rdata = pm_line(pmem_address);
            end
            wait_n   = 0;
            act_prev = 0;
          end else begin
            wait_n++;
          end
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        cyc++;
      end
    end
    chk("timeout", done, 1);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       input int lat, output logic [31:0] rdata);
    int          s, way, e_cyc, cyc, nwb, nfl;
    bit          hit, e_wb, by_ptr;
    logic [23:0] t;
    logic [31:0] e_wba, wba, fla, e_rd, nw;
    logic [255:0] e_wbd, wbd;
    s = int'(a[7:5]);
    t = a[31:8];
    hit = 0; way = 0; e_wb = 0; e_wba = '0; e_wbd = '0;
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mt[s][w] == t) begin hit = 1; way = w; end
    if (hit) begin
      e_cyc = 0;
    end else begin
      way = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) way = w;
      by_ptr = (way < 0);
      if (by_ptr) way = mp[s];
      if (md[s][way]) begin
        e_wb  = 1;
        e_wba = {mt[s][way], 3'(s), 5'b0};
        e_wbd = ref_line(e_wba);
      end
      e_cyc = e_wb ? 3 + 2 * lat : 2 + lat;
      mv[s][way] = 1; md[s][way] = 0; mt[s][way] = t;
      if (by_ptr) mp[s] = (mp[s] + 1) % WAYS;
    end
    e_rd = ref_rd(a);
    access(rd, wr, a, be, wd, lat, rdata, cyc, nwb, wba, wbd, nfl, fla);
    chk("latency", cyc, e_cyc);
    chk("wb_count", nwb, e_wb);
    if (e_wb) begin
      chk("wb_addr", wba, e_wba);
      chk("wb_data", wbd, e_wbd);
    end
    chk("fill_count", nfl, !hit);
    if (!hit) chk("fill_addr", fla, {a[31:5], 5'b0});
    if (wr) begin
      nw = e_rd;
      for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
      refm[a >> 2] = nw;
      md[s][way] = 1;
    end else begin
      chk("rdata", rdata, e_rd);
    end
  endtask

  logic [31:0] r;

  initial begin
    rst = 1'b1; mem_address = '0; mem_read = 0; mem_write = 0;
    mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp", mem_resp, 0);
    chk("rst_pread", pmem_read, 0);
    chk("rst_pwrite", pmem_write, 0);
    chk("rst_paddr", pmem_address, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_pwdata", pmem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(1, 0, 32'h44, 4'h0, 32'h0, 0, r);
    chk("cold_rd", r, 32'h1122_3344);
    do_op(1, 0, 32'h44, 4'h0, 32'h0, 0, r);
    do_op(0, 1, 32'h44, 4'b0011, 32'hAABB_CCDD, 0, r);
    do_op(1, 0, 32'h44, 4'h0, 32'h0, 0, r);
    chk("wr_merge", r, 32'h1122_CCDD);

    do_op(1, 0, 32'h140, 4'h0, 32'h0, 1, r);
    do_op(1, 0, 32'h240, 4'h0, 32'h0, 2, r);
    do_op(1, 0, 32'h140, 4'h0, 32'h0, 0, r);
    do_op(1, 0, 32'h300, 4'h0, 32'h0, 10, r);

    // Abort a fill with reset and confirm the line was dropped.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h5A0;
    for (int i = 0; i < 10 && !pmem_read; i++) begin
      @(negedge clk);
      #1;
    end
    chk("fill_started", pmem_read, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_drop_pread", pmem_read, 0);
    chk("rst_no_resp", mem_resp, 0);
    rst = 1'b0; mem_read = 1'b0;
    model_reset();
    do_op(1, 0, 32'h5A0, 4'h0, 32'h0, 0, r);

    do_op(1, 1, 32'h5A0, 4'hF, 32'hDEAD_BEEF, 0, r);
    do_op(1, 0, 32'h6A0, 4'h0, 32'h0, 0, r);
    do_op(1, 0, 32'h7A0, 4'h0, 32'h0, 1, r);
    do_op(1, 0, 32'h5A0, 4'h0, 32'h0, 0, r);
    chk("rw_as_write", r, 32'hDEAD_BEEF);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          k;
      a = {21'(0), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 2'b0};
      k = $urandom_range(0, 5);
      do_op(k != 1, k <= 1, a, 4'($urandom), $urandom,
            $urandom_range(0, 3), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
